// File: rtl/param_write_arbiter.sv
// param_write_arbiter: shares one data-memory write port between CPU writes
// and a small FIFO of host parameter writes. The CPU wins when it writes;
// queued host writes use the port on cycles the CPU leaves free.
// Optional feature macro: PARAM_WRITE_STARVATION_GUARD_EN. When defined, a
// host write blocked for MaxWait cycles is forced out by stalling the CPU
// for one cycle.
module param_write_arbiter #(
    parameter int DAW       = 10,
    parameter int DWW       = 36,
    parameter int FifoDepth = 4,
    parameter int MaxWait   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DAW-1:0]               cpuAddrW,
    input  logic [DWW-1:0]               cpuDataW,
    input  logic                         cpuWriteEn,
    input  logic [DAW-1:0]               hostAddr,
    input  logic [DWW-1:0]               hostData,
    input  logic                         hostValid,
    output logic                         hostReady,
    output logic [DAW-1:0]               memAddrW,
    output logic [DWW-1:0]               memDataW,
    output logic                         memWriteEn,
    output logic                         cpuStall,
    output logic [$clog2(FifoDepth):0]   fifoCount
);

    localparam int PW = $clog2(FifoDepth);
    localparam int CW = PW + 1;

    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 || MaxWait < 2) begin : g_bad_params
        $error("param_write_arbiter: FifoDepth must be a power of two >= 2 and MaxWait >= 2");
    end

    logic [DAW+DWW-1:0] r_mem [FifoDepth];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_cpu_grant;
    logic               w_stall;
    logic [CW-1:0]      w_count_next;
    logic [DAW+DWW-1:0] w_head;

    assign w_empty     = (r_count == '0);
    assign hostReady   = (r_count < CW'(FifoDepth));
    assign w_push      = hostValid && hostReady;
    assign w_cpu_grant = cpuWriteEn && !w_stall;
    assign w_pop       = !w_cpu_grant && !w_empty;
    assign w_head      = r_mem[r_rd_ptr];
    assign fifoCount   = r_count;
    assign cpuStall    = w_stall;

    // Next occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Write-port mux: CPU grant, else FIFO head, else idle zeros.
    always_comb begin
        memWriteEn = 1'b0;
        memAddrW   = '0;
        memDataW   = '0;
        if (w_cpu_grant) begin
            memWriteEn = 1'b1;
            memAddrW   = cpuAddrW;
            memDataW   = cpuDataW;
        end else if (!w_empty) begin
            memWriteEn = 1'b1;
            memAddrW   = w_head[DAW+DWW-1:DWW];
            memDataW   = w_head[DWW-1:0];
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {hostAddr, hostData};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FifoDepth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

`ifdef PARAM_WRITE_STARVATION_GUARD_EN
    localparam int WW = $clog2(MaxWait);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [WW-1:0]   r_wait;
    logic [WW-1:0]   w_wait_next;
    logic            w_blocked;

    assign w_blocked = !w_empty && w_cpu_grant;
    assign w_stall   = (r_state == FORCE);

    // Starvation FSM state and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
        end
    end

    // Next-state: state tracks occupancy after the edge, so a write queued at
    // edge N sees PEND in cycle N+1 and FORCE lands in cycle N+MaxWait.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        case (r_state)
            IDLE: begin
                w_wait_next = '0;
                if (w_count_next != '0) w_state_next = PEND;
            end
            PEND: begin
                if (w_pop) begin
                    w_wait_next  = '0;
                    w_state_next = (w_count_next == '0) ? IDLE : PEND;
                end else if (w_blocked) begin
                    w_wait_next = r_wait + 1'b1;
                    if (r_wait == WW'(MaxWait - 2)) w_state_next = FORCE;
                end
            end
            FORCE: begin
                w_wait_next  = '0;
                w_state_next = (w_count_next == '0) ? IDLE : PEND;
            end
            default: begin
                w_wait_next  = '0;
                w_state_next = IDLE;
            end
        endcase
    end
`else
    assign w_stall = 1'b0;
`endif

endmodule

// File: doc/param_write_arbiter.md
PARAM_WRITE_ARBITER -- requirements
Module: param_write_arbiter

Interface
REQ-001 SHALL have parameter DAW, default 10, data-memory address width (segment+offset).
REQ-002 SHALL have parameter DWW, default 36, data-memory word width.
REQ-003 SHALL have parameter FifoDepth, default 4, host write queue depth; power of two, at least 2.
REQ-004 SHALL have parameter MaxWait, default 16, consecutive blocked cycles before a forced host slot; at least 2.
REQ-005 SHALL have the following ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state on posedge.
  reset  in  1  asynchronous, active-high.
  cpuAddrW  in  DAW  CPU write address.
  cpuDataW  in  DWW  CPU write data.
  cpuWriteEn  in  1  CPU write request.
  hostAddr  in  DAW  host parameter write address.
  hostData  in  DWW  host parameter write data.
  hostValid  in  1  host write offered.
  hostReady  out  1  queue can accept.
  memAddrW  out  DAW  to data-memory write port address.
  memDataW  out  DWW  to data-memory write port data.
  memWriteEn  out  1  to data-memory write enable.
  cpuStall  out  1  CPU must not write this cycle.
  fifoCount  out  $clog2(FifoDepth)+1  queued host writes.

Function
REQ-006 SHALL accept a host write on each posedge where hostValid and hostReady are both 1, appending {hostAddr, hostData} to the FIFO tail.
REQ-007 SHALL drive hostReady = (fifoCount < FifoDepth); when full, no push occurs even if a pop occurs in the same cycle.
REQ-008 SHALL, combinationally, grant the write port to the CPU when cpuWriteEn=1 and cpuStall=0; memAddrW/memDataW = cpu inputs, memWriteEn=1.
REQ-009 SHALL otherwise grant the port to the FIFO head when FIFO is non-empty; memWriteEn=1 and the head is popped at that posedge.
REQ-010 SHALL drive memWriteEn=0 and memAddrW/memDataW=0 when neither source is granted.
REQ-011 SHALL give minimum latency of one cycle: write accepted at edge N appears on the memory port in cycle N+1 if unblocked.
REQ-012 SHALL issue host writes in strict acceptance order, exactly once each; FIFO pointers wrap modulo FifoDepth.
REQ-013 SHALL update fifoCount by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-014 SHALL never lose a CPU write when cpuStall=0; CPU writes presented while cpuStall=1 are dropped by contract (CPU holds).

Reset
REQ-015 SHALL, on reset assertion, immediately empty the FIFO, clear pointers, wait counter and FSM (IDLE), regardless of clk.
REQ-016 SHALL hold, during and after reset: fifoCount=0, hostReady=1, cpuStall=0, memWriteEn=cpuWriteEn, memAddrW/memDataW per REQ-008/REQ-010.
REQ-017 SHALL discard queued host writes on reset mid-operation; no partial write is issued after reset.

Configuration
REQ-018 SHALL implement, when macro PARAM_WRITE_STARVATION_GUARD_EN is defined, FSM states IDLE (FIFO empty), PEND (non-empty, counting) and FORCE (cpuStall=1).
REQ-019 In that build: IDLE->PEND on non-empty; PEND increments the wait counter each cycle the host is blocked by the CPU, and clears it on each host pop.
REQ-020 In that build: PEND->FORCE at the edge where the counter reaches MaxWait-1 and the host is still blocked; FORCE lasts exactly one cycle, pops the head regardless of cpuWriteEn, then goes to PEND (counter 0) or IDLE if empty.
REQ-021 Without the macro: cpuStall tied 0, no wait counter or FSM, CPU has absolute priority and host writes may starve indefinitely.

Verification
REQ-022 Bench SHALL cover: cpuWriteEn=0, host pushes A=0x105/D=0x1 at edge N -> memWriteEn=1, memAddrW=0x105 in cycle N+1; fifoCount returns to 0.
REQ-023 Bench SHALL cover: 5 back-to-back host pushes with cpuWriteEn=1, FifoDepth=4 -> hostReady=0 after 4 accepted, fifoCount=4, 5th held until a pop.
REQ-024 Bench SHALL cover: cpuWriteEn=1 to 0x2AA and FIFO non-empty -> memAddrW=0x2AA; FIFO head issues first cycle with cpuWriteEn=0.
REQ-025 Bench SHALL cover (guard build): one queued write, cpuWriteEn held 1 -> cpuStall=1 for exactly one cycle, 16 cycles after the write was queued; head issued; cpuStall=0 after.
REQ-026 Bench SHALL cover: 3 writes queued, reset pulsed between edges -> fifoCount=0, hostReady=1 immediately; no queued address ever appears on memAddrW.
REQ-027 Bench SHALL cover: pointer wrap, 10 push/pop pairs with distinct data -> issued sequence equals accepted sequence.
